// File: rtl/conv_sequencer.sv
// Run controller for the conv/pool accelerator: reset hold, weight load, activation stream, drain with timeout.
// Latency: RST_CYC + K*K+1 + N*N cycles to DRAIN; no backpressure, abort returns to IDLE on the next edge.
module conv_sequencer #(
  parameter int N         = 10,
  parameter int K         = 3,
  parameter int RST_CYC   = 20,
  parameter int DRAIN_MAX = 1024
) (
  input  logic                clk,
  input  logic                global_rst,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                err_timeout,
  output logic [7:0]          w_raddr,
  input  logic [15:0]         w_rdata,
  output logic [15:0]         a_raddr,
  input  logic [15:0]         a_rdata,
  output logic                acc_rst,
  output logic                acc_ce,
  output logic [K*K*16-1:0]   acc_weight,
  output logic [15:0]         acc_act,
  input  logic [31:0]         acc_data,
  input  logic                acc_valid,
  input  logic                acc_end,
  output logic                res_we,
  output logic [15:0]         res_waddr,
  output logic [31:0]         res_wdata,
  output logic [15:0]         out_count
);
  localparam int KK = K * K;
  localparam int NN = N * N;

  typedef enum logic [2:0] {IDLE, CLR, LDW, STREAM, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic [31:0]         cnt;
  logic [KK-1:0][15:0] w_q;
  logic [15:0]         act_q;
  logic                act_live;
  logic                ce_q;
  logic                ce_d;
  logic                start_ok;
  logic                timeout_hit;
  logic                cap_en;

  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (state != IDLE) cnt <= cnt + 32'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLR;
      CLR:     if (cnt == 32'(RST_CYC - 1)) state_nxt = LDW;
      LDW:     if (cnt == 32'(KK)) state_nxt = STREAM;
      STREAM:  if (cnt == 32'(NN - 1)) state_nxt = DRAIN;
      DRAIN:   if (acc_end) state_nxt = DONE;
               else if (cnt == 32'(DRAIN_MAX - 1)) state_nxt = IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;

    start_ok    = (state == IDLE) && start && !abort;
    timeout_hit = (state == DRAIN) && !acc_end && !abort && (cnt == 32'(DRAIN_MAX - 1));
    cap_en      = (state == LDW) && !abort;
    // ce stays up only while we remain in the stream/drain phase
    ce_d        = (state == STREAM || state == DRAIN) &&
                  (state_nxt == STREAM || state_nxt == DRAIN);

    busy      = (state != IDLE);
    done      = (state == DONE);
    acc_rst   = (state == CLR);
    w_raddr   = (state == LDW && cnt < 32'(KK)) ? cnt[7:0] : 8'd0;
    a_raddr   = (state == STREAM) ? cnt[15:0] : 16'd0;
    res_we    = (state == STREAM || state == DRAIN) && acc_valid && !acc_end && !abort;
    res_waddr = res_we ? out_count : 16'd0;
    res_wdata = res_we ? acc_data : 32'd0;
  end

  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      w_q         <= '0;
      act_q       <= '0;
      act_live    <= 1'b0;
      ce_q        <= 1'b0;
      out_count   <= '0;
      err_timeout <= 1'b0;
    end else begin
      // a_rdata carries fresh stream data in the cycle after each STREAM address
      act_live <= (state == STREAM) && !abort;
      if (act_live) act_q <= a_rdata;
      ce_q <= ce_d;
      if (start_ok) begin
        out_count   <= '0;
        err_timeout <= 1'b0;
        w_q         <= '0;
      end else begin
        if (res_we && out_count != 16'hFFFF) out_count <= out_count + 16'd1;
        if (timeout_hit) err_timeout <= 1'b1;
        for (int i = 0; i < KK; i++) begin
          if (cap_en && cnt == 32'(i + 1)) w_q[i] <= w_rdata;
        end
      end
    end
  end

  assign acc_weight = w_q;
  assign acc_ce     = ce_q;
  assign acc_act    = act_live ? a_rdata : act_q;

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Run controller for the convolution/pooling accelerator.
- On `start` it does four things in order:
  - holds the accelerator in reset;
  - loads the K*K weight vector from a weight memory into the accelerator's parallel weight bus;
  - streams N*N activations from an activation memory with `ce` asserted;
  - writes every valid accelerator output into a result buffer until `end_op`.
- Sits between the host/top-level and the accelerator, replacing bench-driven sequencing.

Parameters:
- N, 10, input feature-map side; N*N activations per run, max 65535.
- K, 3, kernel side; K*K weights, max 255.
- RST_CYC, 20, accelerator reset hold cycles, min 1.
- DRAIN_MAX, 1024, max cycles in DRAIN before timeout.

Ports:
- clk  in  1  system clock, rising edge.
- global_rst  in  1  asynchronous, active-low reset.
- start  in  1  begin run; sampled in IDLE only.
- abort  in  1  synchronous abort, any state.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at successful end.
- err_timeout  out  1  sticky; set on DRAIN timeout, cleared by next accepted start.
- w_raddr  out  8  weight memory address.
- w_rdata  in  16  weight memory data, 1-cycle read latency.
- a_raddr  out  16  activation memory address.
- a_rdata  in  16  activation data, 1-cycle read latency.
- acc_rst  out  1  active-high reset to accelerator.
- acc_ce  out  1  accelerator clock enable.
- acc_weight  out  K*K*16  weight bus; slot i at bits [i*16 +: 16].
- acc_act  out  16  activation to accelerator.
- acc_data  in  32  accelerator data_out.
- acc_valid  in  1  accelerator valid_op.
- acc_end  in  1  accelerator end_op.
- res_we  out  1  result write enable.
- res_waddr  out  16  result address, 0-based per run.
- res_wdata  out  32  result data.
- out_count  out  16  results written in current/last run.

Behaviour:
- Reset (global_rst=0):
  - state=IDLE.
  - All outputs 0, including acc_weight, out_count and err_timeout.
- States and transitions:
  - IDLE -> CLR on start=1.
  - CLR -> LDW after RST_CYC cycles.
  - LDW -> STREAM after weight load completes.
  - STREAM -> DRAIN after last activation address is issued.
  - DRAIN -> DONE on acc_end=1, or -> IDLE on timeout.
  - DONE -> IDLE after one cycle.
- IDLE:
  - acc_ce=0, acc_rst=0.
  - On start: clear out_count and err_timeout, go to CLR.
- CLR:
  - acc_rst=1 for exactly RST_CYC cycles; acc_ce=0.
  - acc_weight cleared to 0 on entry.
- LDW:
  - w_raddr = 0..K*K-1 on consecutive cycles.
  - Data for address i arrives next cycle and is written to slot i.
  - Exit after K*K+1 cycles, when the last slot is captured.
  - acc_rst=0, acc_ce=0.
- STREAM:
  - a_raddr = 0..N*N-1 on consecutive cycles.
  - Registered: acc_act <= a_rdata and acc_ce <= 1, one cycle behind the address.
  - Result: activation m is on acc_act in the cycle after address m is issued, and acc_ce stays high continuously from the first activation.
  - Exit to DRAIN the cycle after address N*N-1 is issued.
- DRAIN:
  - acc_ce stays 1; acc_act is held at the last activation value.
  - Exit to DONE on acc_end=1.
  - If DRAIN_MAX cycles elapse without acc_end: set err_timeout, drop acc_ce, go to IDLE, no done pulse.
- Result capture (STREAM and DRAIN):
  - Each cycle with acc_valid=1 and acc_end=0: res_we=1, res_wdata=acc_data, res_waddr=out_count; out_count increments the same edge.
  - A cycle with acc_valid=1 and acc_end=1 is not written.
  - acc_valid outside STREAM/DRAIN is ignored.
- DONE:
  - done=1 for one cycle; acc_ce=0; go to IDLE.
  - acc_weight and out_count hold until the next start.
- abort:
  - Has priority over every other transition.
  - Next state IDLE; acc_ce=0, acc_rst=0, res_we=0.
  - No done pulse; out_count and acc_weight hold.
- start while busy=1 is ignored.
- out_count saturates at 16'hFFFF; writes continue at address FFFF.
- Asynchronous reset mid-run: immediate return to IDLE with all outputs 0.

Test Plan:
- Nominal run, N=10, K=3, RST_CYC=20; accelerator model asserts acc_valid 16 times, then acc_end:
  - acc_rst high for exactly 20 cycles.
  - w_raddr 0..8; acc_weight slot i equals weight memory word i.
  - 100 consecutive acc_ce cycles carry a_rdata 0..99 in order.
  - res_waddr 0..15 written with the model's data; out_count=16; one done pulse; busy falls the cycle after done.
- Weight ordering: weight memory holds 16'h0001..16'h0009 -> acc_weight = {16'h0009, ..., 16'h0001}, slot 0 in the low bits.
- Coincident end: acc_valid=1 and acc_end=1 in the same cycle -> no res_we that cycle; done on the next cycle.
- Timeout: model never asserts acc_end, DRAIN_MAX=1024:
  - err_timeout=1 after 1024 DRAIN cycles; acc_ce=0; no done pulse; state IDLE.
  - Next start clears err_timeout.
- Abort mid-STREAM at activation 40 -> acc_ce=0 the next cycle; IDLE; start during the abort cycle is ignored; a new start then yields a full correct run.
- start pulsed during LDW is ignored, giving exactly one run; global_rst asserted in DRAIN zeroes acc_ce, out_count and acc_weight immediately.
